// File: rtl/fetch_unit_pkg.sv
// Shared PC-sequencing encodings and helpers for the fetch stage.
// Pure declarations; no timing or flow control of its own.
package fetch_unit_pkg;

    typedef enum logic [3:0] {
        PC_OP_NEXT  = 4'd0,
        PC_OP_J     = 4'd1,
        PC_OP_JR    = 4'd2,
        PC_OP_BZ    = 4'd3,
        PC_OP_BNZ   = 4'd4,
        PC_OP_BGZ   = 4'd5,
        PC_OP_BNGNZ = 4'd6,
        PC_OP_BNG   = 4'd7,
        PC_OP_BG    = 4'd8
    } pc_op_e;

    // Branch displacement: sign-extended 16-bit word offset, in bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC target and branch-condition logic, purely combinational (0 cycles).
// No flow control: result is meaningful only when the caller qualifies it.
module fetch_unit_next_pc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] rs_val_i,
    input  logic [3:0]  pc_op_i,
    input  logic        alu_zero_i,
    input  logic        alu_neg_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic        taken;
    logic [31:0] branch_tgt;

    assign branch_tgt = pc_plus4_i + branch_offset(imm26_i[15:0]);

    always_comb begin
        taken     = 1'b0;
        next_pc_o = pc_plus4_i;
        case (pc_op_i)
            PC_OP_J:     next_pc_o = {pc_plus4_i[31:28], imm26_i, 2'b00};
            PC_OP_JR:    next_pc_o = rs_val_i;
            PC_OP_BZ:    taken = alu_zero_i;
            PC_OP_BNZ:   taken = !alu_zero_i;
            PC_OP_BGZ:   taken = !alu_neg_i;
            PC_OP_BNGNZ: taken = alu_neg_i;
            PC_OP_BNG:   taken = alu_neg_i | alu_zero_i;
            PC_OP_BG:    taken = !alu_neg_i & !alu_zero_i;
            default:     next_pc_o = pc_plus4_i;
        endcase
        if (taken) begin
            next_pc_o = branch_tgt;
        end
    end

    // Only JR can produce a misaligned target; jumps and branches stay word-aligned.
    assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC-sequencing stage: FETCH -> EXEC per instruction, min 2 cycles each.
// imem_req held until imem_ack; EXEC holds ins until ex_done; misaligned target halts.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [3:0]  pc_op,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic [31:0] rs_val,
    input  logic        ex_done,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] ins_q, ins_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;

    logic [31:0] npc;
    logic        npc_misaligned;

    fetch_unit_next_pc u_next_pc (
        .pc_plus4_i   (pc_plus4_q),
        .imm26_i      (ins_q[25:0]),
        .rs_val_i     (rs_val),
        .pc_op_i      (pc_op),
        .alu_zero_i   (alu_zero),
        .alu_neg_i    (alu_neg),
        .next_pc_o    (npc),
        .misaligned_o (npc_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        ins_d      = ins_q;
        err_d      = err_q;
        case (state_q)
            ST_FETCH: begin
                // req_q gates acceptance so the reset-release cycle cannot take an ack.
                if (imem_ack && req_q) begin
                    ins_d   = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    if (npc_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d       = npc;
                        pc_plus4_d = npc + 32'd4;
                        state_d    = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
            ins_q      <= 32'd0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            ins_q      <= ins_d;
            err_q      <= err_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign ins_valid = valid_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand sequences, a next-PC vector table, and a randomized run
// against a transaction-level reference of the PC rules.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [3:0]  pc_op = 4'd0;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic [31:0] rs_val = 32'd0;
    logic        ex_done = 1'b0;
    logic        fetch_err;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .pc_op      (pc_op),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .rs_val     (rs_val),
        .ex_done    (ex_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        imem_ack = 1'b0;
        ex_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !imem_req; i++) @(negedge clk);
        chk1("req_timeout", imem_req, 1'b1);
    endtask

    task automatic fetch(input logic [31:0] d);
        wait_req();
        imem_rdata = d;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk1("fetch_valid", ins_valid, 1'b1);
    endtask

    task automatic exec(input logic [3:0] op, input logic z, input logic n, input logic [31:0] rs);
        pc_op = op;
        alu_zero = z;
        alu_neg = n;
        rs_val = rs;
        ex_done = 1'b1;
        @(negedge clk);
        ex_done = 1'b0;
    endtask

    // Reference next-PC from the PC-sequencing rules, plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] i,
                                             input int op, input bit z, input bit n,
                                             input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        bit          taken;
        p4 = p + 32'd4;
        off = int'(signed'(i[15:0])) * 4;
        taken = 1'b0;
        case (op)
            1: return {p4[31:28], i[25:0], 2'b00};
            2: return rs;
            3: taken = z;
            4: taken = !z;
            5: taken = !n;
            6: taken = n;
            7: taken = n || z;
            8: taken = !n && !z;
            default: return p4;
        endcase
        return taken ? p4 + 32'(off) : p4;
    endfunction

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] ins;
        logic [3:0]  op;
        logic        zero;
        logic        neg;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mkv(input logic [31:0] s, input logic [31:0] i, input logic [3:0] op,
                                 input logic n, input logic z, input logic [31:0] rs,
                                 input logic [31:0] e, input logic err);
        vec_t v;
        v.start_pc = s; v.ins = i; v.op = op; v.neg = n; v.zero = z;
        v.rs = rs; v.exp_pc = e; v.exp_err = err;
        return v;
    endfunction

    vec_t vt[24];

    initial begin
        logic [31:0] mpc;
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] exp_pc;
        logic [3:0]  rop;
        logic [31:0] rrs;
        bit          rz, rn;

        // beq at 0x100, imm -2
        vt[0]  = mkv(32'h100, 32'h1000_FFFE, 4'd3, 0, 1, 0, 32'h0FC, 0);
        vt[1]  = mkv(32'h100, 32'h1000_FFFE, 4'd3, 0, 0, 0, 32'h104, 0);
        vt[2]  = mkv(32'h100, 32'h1400_0010, 4'd4, 0, 0, 0, 32'h144, 0);
        // bltz / bgez / blez / bgtz over (neg,zero) = (0,0),(0,1),(1,0); imm +0x10
        vt[3]  = mkv(32'h100, 32'h0400_0010, 4'd6, 0, 0, 0, 32'h104, 0);
        vt[4]  = mkv(32'h100, 32'h0400_0010, 4'd6, 0, 1, 0, 32'h104, 0);
        vt[5]  = mkv(32'h100, 32'h0400_0010, 4'd6, 1, 0, 0, 32'h144, 0);
        vt[6]  = mkv(32'h100, 32'h0400_0010, 4'd5, 0, 0, 0, 32'h144, 0);
        vt[7]  = mkv(32'h100, 32'h0400_0010, 4'd5, 0, 1, 0, 32'h144, 0);
        vt[8]  = mkv(32'h100, 32'h0400_0010, 4'd5, 1, 0, 0, 32'h104, 0);
        vt[9]  = mkv(32'h100, 32'h1800_0010, 4'd7, 0, 0, 0, 32'h104, 0);
        vt[10] = mkv(32'h100, 32'h1800_0010, 4'd7, 0, 1, 0, 32'h144, 0);
        vt[11] = mkv(32'h100, 32'h1800_0010, 4'd7, 1, 0, 0, 32'h144, 0);
        vt[12] = mkv(32'h100, 32'h1C00_0010, 4'd8, 0, 0, 0, 32'h144, 0);
        vt[13] = mkv(32'h100, 32'h1C00_0010, 4'd8, 0, 1, 0, 32'h104, 0);
        vt[14] = mkv(32'h100, 32'h1C00_0010, 4'd8, 1, 0, 0, 32'h104, 0);
        // jumps, jr, wrap and undefined encodings
        vt[15] = mkv(32'hA000_0010, 32'h0800_0040, 4'd1, 0, 0, 0, 32'hA000_0100, 0);
        vt[16] = mkv(32'h0FFF_FFFC, 32'h0BFF_FFFF, 4'd1, 0, 0, 0, 32'h1FFF_FFFC, 0);
        vt[17] = mkv(32'hFFFF_FFFC, 32'h0800_0040, 4'd1, 0, 0, 0, 32'h0000_0100, 0);
        vt[18] = mkv(32'h100, 32'h0000_0008, 4'd2, 0, 0, 32'h2000, 32'h2000, 0);
        vt[19] = mkv(32'h100, 32'h0000_0008, 4'd2, 0, 0, 32'h2002, 32'h100, 1);
        vt[20] = mkv(32'hFFFF_FFFC, 32'h0, 4'd0, 0, 0, 0, 32'h0, 0);
        vt[21] = mkv(32'h0, 32'h1000_FFFE, 4'd3, 0, 1, 0, 32'hFFFF_FFFC, 0);
        vt[22] = mkv(32'h100, 32'h1000_FFFE, 4'd15, 0, 1, 0, 32'h104, 0);
        vt[23] = mkv(32'h100, 32'h1000_FFFE, 4'd9, 0, 1, 32'h3, 32'h104, 0);

        // Reset values while rst is held high
        repeat (3) @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_pc", pc, RPC);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_pc4", pc_plus4, RPC + 32'd4);
        chk("rst_ins", ins, 32'd0);
        chk1("rst_valid", ins_valid, 1'b0);
        chk1("rst_err", fetch_err, 1'b0);

        // First fetch with a zero-wait memory
        rst = 1'b0;
        @(negedge clk);
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, RPC);
        chk1("first_valid0", ins_valid, 1'b0);
        imem_rdata = 32'h2408_0005;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk1("first_valid", ins_valid, 1'b1);
        chk1("first_req_drop", imem_req, 1'b0);
        chk("first_ins", ins, 32'h2408_0005);
        exec(4'd0, 0, 0, 0);
        chk1("next_req", imem_req, 1'b1);
        chk1("next_valid", ins_valid, 1'b0);
        chk("next_addr", imem_addr, 32'hBFC0_0004);
        chk("next_pc4", pc_plus4, 32'hBFC0_0008);

        // 5-cycle memory stall, then a spurious ack during EXEC
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_addr", imem_addr, 32'hBFC0_0004);
            chk1("stall_req", imem_req, 1'b1);
            chk("stall_ins", ins, 32'h2408_0005);
        end
        fetch(32'h1111_2222);
        chk("stall_fetched", ins, 32'h1111_2222);
        imem_rdata = 32'h3333_4444;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("spurious_ins", ins, 32'h1111_2222);
        chk1("spurious_valid", ins_valid, 1'b1);
        exec(4'd0, 0, 0, 0);
        chk("after_stall_addr", imem_addr, 32'hBFC0_0008);

        // Reset during FETCH coinciding with a late ack
        chk1("pre_rst_req", imem_req, 1'b1);
        rst = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk1("rstfetch_req", imem_req, 1'b0);
        chk("rstfetch_ins", ins, 32'd0);
        chk1("rstfetch_valid", ins_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("refetch_req", imem_req, 1'b1);
        chk("refetch_addr", imem_addr, RPC);
        chk("refetch_ins", ins, 32'd0);

        // Next-PC vector table: steer to start_pc via JR, then execute the vector
        for (int k = 0; k < 24; k++) begin
            reset_dut();
            fetch(32'd0);
            exec(4'd2, 0, 0, vt[k].start_pc);
            wait_req();
            chk("tbl_start", imem_addr, vt[k].start_pc);
            fetch(vt[k].ins);
            exec(vt[k].op, vt[k].zero, vt[k].neg, vt[k].rs);
            if (vt[k].exp_err) begin
                chk1("tbl_err", fetch_err, 1'b1);
                chk("tbl_pc_held", pc, vt[k].exp_pc);
                for (int h = 0; h < 3; h++) begin
                    imem_ack = 1'b1;
                    pc_op = 4'd0;
                    ex_done = 1'b1;
                    @(negedge clk);
                    imem_ack = 1'b0;
                    ex_done = 1'b0;
                    chk1("halt_req", imem_req, 1'b0);
                    chk1("halt_valid", ins_valid, 1'b0);
                    chk1("halt_err", fetch_err, 1'b1);
                    chk("halt_pc", pc, vt[k].exp_pc);
                end
            end else begin
                chk1("tbl_noerr", fetch_err, 1'b0);
                chk1("tbl_req", imem_req, 1'b1);
                chk("tbl_next", imem_addr, vt[k].exp_pc);
            end
        end

        // Randomized run against the reference model
        reset_dut();
        mpc = RPC;
        for (int k = 0; k < 300; k++) begin
            wait_req();
            chk("rnd_addr", imem_addr, mpc);
            chk("rnd_pc4", pc_plus4, mpc + 32'd4);
            for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    pc_op = 4'd2;
                    rs_val = $urandom;
                    ex_done = 1'b1;
                end
                @(negedge clk);
                ex_done = 1'b0;
                chk("rnd_stall_addr", imem_addr, mpc);
            end
            d = $urandom;
            fetch(d);
            chk("rnd_ins", ins, d);
            for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                if ($urandom_range(0, 1) == 1) begin
                    imem_rdata = ~d;
                    imem_ack = 1'b1;
                end
                @(negedge clk);
                imem_ack = 1'b0;
                chk("rnd_ins_hold", ins, d);
            end
            rop = 4'($urandom_range(0, 15));
            rz = 1'($urandom_range(0, 1));
            rn = 1'($urandom_range(0, 1));
            a = $urandom;
            rrs = ($urandom_range(0, 7) == 0) ? a : {a[31:2], 2'b00};
            exp_pc = ref_next(mpc, d, int'(rop), rz, rn, rrs);
            exec(rop, rz, rn, rrs);
            if (exp_pc[1:0] != 2'b00) begin
                chk1("rnd_err", fetch_err, 1'b1);
                chk("rnd_pc_held", pc, mpc);
                chk1("rnd_halt_req", imem_req, 1'b0);
                reset_dut();
                mpc = RPC;
            end else begin
                chk1("rnd_noerr", fetch_err, 1'b0);
                mpc = exp_pc;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
